fib_seq_gen: RTL and testbench

- Parametrised generalised-Fibonacci (Lucas-type) sequence generator with programmable seeds, a programmable term count and a valid/ready streaming output.
- Per-term overflow flag plus a sticky summary flag.
- Successor to the free-running fixed-seed counter; sits as a test-pattern / reference-sequence source in front of stream consumers.

---
 rtl/fib_pkg.sv | 19 +
 rtl/fib_add.sv | 37 +++
 rtl/fib_seq_gen.sv | 110 +++++++++++
 tb/tb_fib_seq_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// ============================================================================
// fib_pkg : shared state encoding and default sizes for fib_seq_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

package fib_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_IDX_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fib_add.sv
// ============================================================================
// fib_add : (WIDTH+1)-bit adder producing the next term and its overflow flag
// Optional macro FIB_SAT_EN selects saturating instead of modulo arithmetic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fib_add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ovf_in,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b};

`ifdef FIB_SAT_EN
  // A saturated newest term keeps every later term pinned at all-ones.
  logic sat;
  assign sat = full[WIDTH] | ovf_in;
  assign sum = sat ? {WIDTH{1'b1}} : full[WIDTH-1:0];
  assign ovf = sat;
`else
  logic unused_ovf_in;
  assign unused_ovf_in = ovf_in;
  assign sum = full[WIDTH-1:0];
  assign ovf = full[WIDTH];
`endif

endmodule

`default_nettype wire

// File: rtl/fib_seq_gen.sv
// ============================================================================
// fib_seq_gen : seeded generalised-Fibonacci stream source, valid/ready output
// Optional macro FIB_SAT_EN (in fib_add) selects saturating arithmetic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [IDX_W-1:0] n_terms,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_ovf,
  output logic             busy,
  output logic             ovf_seen
);

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_ovf;
  logic             b_ovf;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] len;
  logic             seen;
  logic [WIDTH-1:0] nxt;
  logic             nxt_ovf;
  logic             running;
  logic             last;

  fib_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .a      (a),
    .b      (b),
    .ovf_in (b_ovf),
    .sum    (nxt),
    .ovf    (nxt_ovf)
  );

  assign running = (state == RUN);
  assign last    = running && (idx == len - 1'b1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
      idx   <= '0;
      len   <= '0;
      seen  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (n_terms != '0)) begin
            a     <= seed_a;
            b     <= seed_b;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
            idx   <= '0;
            len   <= n_terms;
            seen  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            seen <= seen | a_ovf;
            // The final term stays on the outputs after the stream ends.
            if (last) begin
              state <= IDLE;
            end else begin
              a     <= b;
              a_ovf <= b_ovf;
              b     <= nxt;
              b_ovf <= nxt_ovf;
              idx   <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = running;
  assign busy      = running;
  assign out_data  = a;
  assign out_idx   = idx;
  assign out_last  = last;
  assign out_ovf   = running & a_ovf;
  assign ovf_seen  = seen;

endmodule

`default_nettype wire

// File: tb/tb_fib_seq_gen.sv
// ============================================================================
// tb_fib_seq_gen : directed self-checking bench for fib_seq_gen (WIDTH=8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fib_seq_gen;

  localparam int WIDTH = 8;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] seed_a = '0;
  logic [WIDTH-1:0] seed_b = '0;
  logic [IDX_W-1:0] n_terms = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_ovf;
  logic             busy;
  logic             ovf_seen;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fib_seq_gen #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .seed_a    (seed_a),
    .seed_b    (seed_b),
    .n_terms   (n_terms),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ovf   (out_ovf),
    .busy      (busy),
    .ovf_seen  (ovf_seen)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb,
                        input logic [IDX_W-1:0] n);
    seed_a  = sa;
    seed_b  = sb;
    n_terms = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, out_valid, 0);
    chk({tag, " data"},  out_data,  0);
    chk({tag, " idx"},   out_idx,   0);
    chk({tag, " last"},  out_last,  0);
    chk({tag, " ovf"},   out_ovf,   0);
    chk({tag, " busy"},  busy,      0);
    chk({tag, " seen"},  ovf_seen,  0);
  endtask

  int fib10 [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
  int luc6  [6]  = '{2, 1, 3, 4, 7, 11};
`ifdef FIB_SAT_EN
  int fib16 [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 255, 255};
`else
  int fib16 [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
`endif
  int ovf16 [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  int rdy_pat [4] = '{1, 0, 0, 1};

  initial begin
    int j;
    int cyc;
    logic rdy;

    // Reset state
    #1;
    chk_zero("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    chk_zero("idle");

    // Plain Fibonacci, full throughput, with a stray start mid-run
    out_ready = 1'b1;
    launch(0, 1, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1 valid[%0d]", k), out_valid, 1);
      chk($sformatf("t1 data[%0d]", k), out_data, fib10[k]);
      chk($sformatf("t1 idx[%0d]", k), out_idx, k);
      chk($sformatf("t1 last[%0d]", k), out_last, (k == 9) ? 1 : 0);
      chk($sformatf("t1 ovf[%0d]", k), out_ovf, 0);
      if (k == 3) begin
        seed_a  = 8'd7;
        seed_b  = 8'd9;
        n_terms = 8'd3;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("t1 end valid", out_valid, 0);
    chk("t1 end busy", busy, 0);

    // Lucas seeds under toggling backpressure
    launch(2, 1, 6);
    j   = 0;
    cyc = 0;
    while (j < 6 && cyc < 40) begin
      chk($sformatf("t2 valid c%0d", cyc), out_valid, 1);
      chk($sformatf("t2 data c%0d", cyc), out_data, luc6[j]);
      chk($sformatf("t2 idx c%0d", cyc), out_idx, j);
      rdy = rdy_pat[cyc % 4] != 0;
      out_ready = rdy;
      tick();
      if (rdy) j++;
      cyc++;
    end
    chk("t2 terms accepted", j, 6);
    chk("t2 end valid", out_valid, 0);

    // Overflow at 8 bits
    out_ready = 1'b1;
    launch(0, 1, 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t3 data[%0d]", k), out_data, fib16[k]);
      chk($sformatf("t3 ovf[%0d]", k), out_ovf, ovf16[k]);
      chk($sformatf("t3 idx[%0d]", k), out_idx, k);
      chk($sformatf("t3 seen[%0d]", k), ovf_seen, (k >= 15) ? 1 : 0);
      tick();
    end
    chk("t3 seen after", ovf_seen, 1);
    chk("t3 end busy", busy, 0);

    // Zero-length request is ignored
    launch(3, 4, 0);
    chk("t4 busy", busy, 0);
    chk("t4 valid", out_valid, 0);
    tick();
    chk("t4 busy2", busy, 0);

    // Asynchronous reset mid-run, then a fresh sequence
    launch(0, 1, 10);
    for (int k = 0; k < 4; k++) tick();
    chk("t5 pre idx", out_idx, 4);
    chk("t5 pre data", out_data, 3);
    #2;
    rstn = 1'b0;
    #1;
    chk_zero("t5 async");
    tick();
    rstn = 1'b1;
    tick();
    launch(5, 5, 4);
    chk("t5 d0", out_data, 5);
    tick();
    chk("t5 d1", out_data, 5);
    tick();
    chk("t5 d2", out_data, 10);
    tick();
    chk("t5 d3", out_data, 15);
    chk("t5 last", out_last, 1);
    tick();
    chk("t5 end valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
